// File: rtl/root_fanin_merge5.sv
// rtl/root_fanin_merge5.sv - round-robin fan-in of N_IN child streams into one registered upstream stream
// Optional feature macro: MERGE_GRANT_CNT_EN (adds the 16-bit grant_cnt output port)
module root_fanin_merge5 #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 5,
  parameter int SRC_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_valid,
  output logic [N_IN-1:0]          in_ready,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_src
`ifdef MERGE_GRANT_CNT_EN
  ,
  output logic [15:0]              grant_cnt
`endif
);

  logic [SRC_W-1:0]  ptr;
  logic              load;
  logic              found;
  logic [SRC_W-1:0]  grant;
  logic [DATA_W-1:0] grant_data;
  logic [N_IN-1:0]   grant_onehot;
  logic              xfer;
  logic [SRC_W-1:0]  ptr_next;
  logic [DATA_W-1:0] child_data [N_IN];

  // The output register can take a new beat when empty or being drained this cycle
  assign load = !out_valid || out_ready;

  // Unpack the flat payload bus into one word per child
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      child_data[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan children starting at ptr and wrapping; the first requester wins
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    found      = 1'b0;
    grant      = '0;
    grant_data = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < N_IN; k++) begin
      sum = {1'b0, ptr} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(N_IN)) begin
        sum = sum - (SRC_W+1)'(N_IN);
      end
      idx = sum[SRC_W-1:0];
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant      = idx;
        grant_data = child_data[idx];
      end
    end
  end

  // One-hot accept for the granted child; nothing is accepted during reset
  always_comb begin
    grant_onehot = '0;
    if (found) begin
      grant_onehot = N_IN'(1) << grant;
    end
  end

  assign in_ready = {N_IN{load && found && !rst}} & grant_onehot;
  assign xfer     = load && found && !rst;
  assign ptr_next = (grant == SRC_W'(N_IN-1)) ? '0 : grant + 1'b1;

  // Output holding register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MERGE_GRANT_CNT_EN
  // Free-running count of accepted input beats, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (xfer) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_root_fanin_merge5.sv
// tb/tb_root_fanin_merge5.sv - self-checking bench for root_fanin_merge5
module tb_root_fanin_merge5;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
`ifdef MERGE_GRANT_CNT_EN
  logic [15:0]     grant_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural reference state
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_data  = '0;
  int          m_src   = 0;
  logic [15:0] m_cnt   = '0;

  logic [N-1:0] seen_ready;
  logic [N-1:0] want_ready;

  root_fanin_merge5 #(.DATA_W(DW), .N_IN(N), .SRC_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef MERGE_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input logic r);
    int g;
    g = exp_grant();
    if (r || g < 0 || !(!m_valid || out_ready)) return '0;
    return N'(1) << g;
  endfunction

  task automatic model_edge(input logic r);
    int g;
    g = exp_grant();
    if (r) begin
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_src = 0; m_cnt = '0;
    end else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*DW +: DW];
        m_src   = g;
        m_ptr   = (g + 1) % N;
        m_cnt   = m_cnt + 16'd1;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // drive one cycle, capture in_ready before the edge, advance the model at the edge
  task automatic tick(input logic r, input logic [N-1:0] v, input logic orr, input logic [N*DW-1:0] d);
    @(negedge clk);
    rst = r; in_valid = v; out_ready = orr; in_data = d;
    #1;
    seen_ready = in_ready;
    want_ready = exp_ready(r);
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  function automatic logic [N*DW-1:0] ramp_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'hA0 + 8'(i);
    return d;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, '1, 1'b1, ramp_data());
      n_checks++; if (seen_ready !== 5'b0) $display("FAIL reset_in_ready: got %b want 00000", seen_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_src !== 3'd0) $display("FAIL reset_out_src: got %0d want 0", out_src); else n_pass++;
    end
    tick(1'b0, '1, 1'b1, ramp_data());
    n_checks++; if (seen_ready !== 5'b00001) $display("FAIL reset_first_ready: got %b want 00001", seen_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_src !== 3'd0) $display("FAIL reset_first_grant: got v=%b src=%0d want v=1 src=0", out_valid, out_src); else n_pass++;
  endtask

  task automatic test_round_robin();
    tick(1'b1, '0, 1'b1, '0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, '1, 1'b1, ramp_data());
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== 3'(k % N) || out_data !== 8'hA0 + 8'(k % N))
        $display("FAIL rr_beat%0d: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                 k, out_valid, out_src, out_data, k % N, 8'hA0 + 8'(k % N));
      else n_pass++;
    end
  endtask

  task automatic test_sparse();
    int want [3] = '{3, 1, 3};
    tick(1'b1, '0, 1'b1, '0);
    tick(1'b0, 5'b00010, 1'b1, ramp_data());
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 5'b01010, 1'b1, ramp_data());
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== 3'(want[k]))
        $display("FAIL sparse_%0d: got v=%b src=%0d want v=1 src=%0d", k, out_valid, out_src, want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [N*DW-1:0] d;
    d = ramp_data();
    d[2*DW +: DW] = 8'h5C;
    tick(1'b1, '0, 1'b1, '0);
    tick(1'b0, '0, 1'b1, '0);
    tick(1'b0, '0, 1'b1, '0);
    // move ptr to 2 by granting child 1 first, then child 2
    tick(1'b0, 5'b00010, 1'b1, d);
    tick(1'b0, 5'b00100, 1'b1, d);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, '1, 1'b0, d);
      n_checks++;
      if (seen_ready !== 5'b0 || out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== 8'h5C)
        $display("FAIL bp_hold%0d: got rdy=%b v=%b src=%0d data=%h want rdy=00000 v=1 src=2 data=5c",
                 c, seen_ready, out_valid, out_src, out_data);
      else n_pass++;
    end
    tick(1'b0, '1, 1'b1, d);
    n_checks++; if (seen_ready !== 5'b01000) $display("FAIL bp_release_ready: got %b want 01000", seen_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== 8'hA3)
      $display("FAIL bp_no_bubble: got v=%b src=%0d data=%h want v=1 src=3 data=a3", out_valid, out_src, out_data); else n_pass++;
  endtask

  task automatic test_wrap_idle();
    tick(1'b1, '0, 1'b1, '0);
    tick(1'b0, 5'b10000, 1'b1, ramp_data());
    n_checks++; if (out_valid !== 1'b1 || out_src !== 3'd4) $display("FAIL wrap_grant4: got v=%b src=%0d want v=1 src=4", out_valid, out_src); else n_pass++;
    tick(1'b0, '0, 1'b1, ramp_data());
    n_checks++; if (out_valid !== 1'b0 || seen_ready !== 5'b0) $display("FAIL idle_drop: got v=%b rdy=%b want v=0 rdy=00000", out_valid, seen_ready); else n_pass++;
    tick(1'b0, '1, 1'b1, ramp_data());
    n_checks++; if (seen_ready !== 5'b00001 || out_src !== 3'd0 || out_data !== 8'hA0)
      $display("FAIL wrap_child0: got rdy=%b src=%0d data=%h want rdy=00001 src=0 data=a0", seen_ready, out_src, out_data); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] r64;
    tick(1'b1, '0, 1'b1, '0);
    for (int c = 0; c < 400; c++) begin
      r64 = {$urandom, $urandom};
      tick(($urandom_range(0, 39) == 0), N'($urandom), ($urandom_range(0, 3) != 0), r64[N*DW-1:0]);
      n_checks++;
      if (seen_ready !== want_ready || out_valid !== m_valid || out_data !== m_data || out_src !== 3'(m_src))
        $display("FAIL random_%0d: got rdy=%b v=%b data=%h src=%0d want rdy=%b v=%b data=%h src=%0d",
                 c, seen_ready, out_valid, out_data, out_src, want_ready, m_valid, m_data, m_src);
      else n_pass++;
`ifdef MERGE_GRANT_CNT_EN
      n_checks++; if (grant_cnt !== m_cnt) $display("FAIL random_cnt_%0d: got %0d want %0d", c, grant_cnt, m_cnt); else n_pass++;
`endif
    end
  endtask

`ifdef MERGE_GRANT_CNT_EN
  task automatic test_grant_cnt();
    tick(1'b1, '1, 1'b1, ramp_data());
    n_checks++; if (grant_cnt !== 16'd0) $display("FAIL cnt_reset: got %0d want 0", grant_cnt); else n_pass++;
    for (int c = 0; c < 65537; c++) tick(1'b0, '1, 1'b1, ramp_data());
    n_checks++; if (grant_cnt !== 16'd1) $display("FAIL cnt_wrap: got %0d want 1", grant_cnt); else n_pass++;
    tick(1'b0, '1, 1'b1, ramp_data());
    tick(1'b0, '1, 1'b1, ramp_data());
    tick(1'b1, '1, 1'b1, ramp_data());
    n_checks++; if (grant_cnt !== 16'd0) $display("FAIL cnt_mid_reset: got %0d want 0", grant_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_wrap_idle();
    test_random();
`ifdef MERGE_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/root_fanin_merge5.md
Name: root_fanin_merge5

Overview:
- Fan-in counterpart to the root-level fan-out hierarchy: merges valid/ready streams from N_IN child instances into one upstream stream.
- Fair round-robin arbitration.
- One registered output stage.
- Tags each output beat with the index of the child that sourced it.
- Sits in the root module, between the child instances and the single upstream consumer.

Parameters:
- DATA_W, 8, payload width per beat.
- N_IN, 5, number of child input streams; legal range 2..8.
- SRC_W, 3, width of the source tag; must be at least ceil(log2(N_IN)).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N_IN  per-child beat valid; bit i belongs to child i.
- in_ready  output  N_IN  per-child accept; at most one bit high per cycle.
- in_data  input  N_IN*DATA_W  child i payload at bits [i*DATA_W +: DATA_W].
- out_valid  output  1  upstream beat valid.
- out_ready  input  1  upstream accept.
- out_data  output  DATA_W  upstream payload.
- out_src  output  SRC_W  index of the child that produced out_data.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high on clk/rst.
  - While rst is high: out_valid=0, out_data=0, out_src=0, in_ready=all 0, ptr=0.
- State:
  - Output holding register: out_valid, out_data, out_src.
  - Round-robin pointer ptr, SRC_W bits, range 0..N_IN-1.
- load = !out_valid || out_ready. This is the register-free-or-draining condition.
- Grant (combinational):
  - g = first index i with in_valid[i]=1, scanning ptr, ptr+1, …, N_IN-1, 0, …, ptr-1.
  - in_ready[g] = load && any(in_valid). All other in_ready bits are 0.
- Transfer on child g: in_valid[g] && in_ready[g] at a rising edge. Next cycle:
  - out_data <= slice g.
  - out_src <= g.
  - out_valid <= 1.
  - ptr <= (g == N_IN-1) ? 0 : g+1.
- If load=1 and no in_valid is set: out_valid <= 0; out_data/out_src hold their previous values; ptr unchanged.
- If load=0 (out_valid=1, out_ready=0): out_valid, out_data and out_src are held stable; in_ready=all 0; ptr unchanged.
- Latency: exactly 1 cycle from input handshake to out_valid.
- Throughput: 1 beat per cycle while out_ready is held high.
- Simultaneous upstream drain and new grant in the same cycle: the new beat replaces the old with no bubble.
- Fairness: with all N_IN inputs continuously valid and out_ready=1, grants cycle 0,1,…,N_IN-1,0 with no repeats inside a round.
- Dependency rules:
  - in_ready may depend combinationally on in_valid and out_ready.
  - Children must not make in_valid depend on in_ready.
  - A child holds in_valid and its data stable until accepted; the block does not check this.
- Reset mid-operation: any beat held in the output register is discarded, ptr returns to 0, and no handshake completes in a reset cycle.

Optional Feature:
- Macro MERGE_GRANT_CNT_EN.
- When defined:
  - Adds output port grant_cnt, 16 bits.
  - grant_cnt increments by 1 on every input transfer and wraps 16'hFFFF -> 0.
  - Reset value 0; cleared by rst.
  - It is not incremented on the reset cycle.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_src=0 throughout; first grant after release is child 0.
- Round-robin: all five in_valid=1 with data 8'hA0+i, out_ready=1 for 10 cycles -> out_src sequence 0,1,2,3,4,0,1,2,3,4; out_data matches A0..A4; one beat every cycle.
- Sparse requests: only in_valid[3] and in_valid[1] high, ptr=2 -> first grant 3, then 1, then 3; out_src = 3,1,3.
- Backpressure: out_valid=1 holding src 2/data 8'h5C, out_ready=0 for 4 cycles -> out_data/out_src unchanged, in_ready=0; at out_ready=1 the next child is granted in the same cycle, with no bubble.
- Wrap and idle: grant child 4, then all in_valid=0 -> ptr=0, out_valid drops the cycle after out_ready; when child 0 raises in_valid it is granted first.
- MERGE_GRANT_CNT_EN: 65537 transfers from reset -> grant_cnt=1; an asserted rst mid-stream sets grant_cnt=0 on the next edge.
